keypad_countdown_ctrl: RTL

Parametrised keypad entry and countdown controller for the project display path. It takes 5-bit keypad codes and builds a multi-digit BCD value from digit presses. On a RUN key it counts that value down at a divided tick rate, and it drops to a lockout state after a configurable idle period. It sits between the keypad scanner and the seven-segment display driver.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/bcd_decrement.sv | 18 +
 rtl/keypad_countdown_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes and state encoding shared by the keypad countdown controller
package keypad_pkg;
  localparam logic [4:0] KEY_NONE  = 5'h1F;
  localparam logic [4:0] KEY_CLEAR = 5'h1E;
  localparam logic [4:0] KEY_ARM   = 5'h1C;
  localparam logic [4:0] KEY_RUN   = 5'h18;
  typedef enum logic [2:0] {
    LOCK  = 3'd0,
    IDLE  = 3'd1,
    ENTRY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5,
    PAUSE = 3'd6
  } state_t;
  function automatic logic is_digit(logic [4:0] k);
    return k <= 5'h09;
  endfunction
endpackage

// File: rtl/bcd_decrement.sv
// bcd_decrement: combinational multi-digit BCD minus one with borrow between digits
module bcd_decrement #(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] result
);
  logic [DIGITS-1:0] borrow;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign borrow[i] = 1'b1;
    end else begin : g_up
      assign borrow[i] = borrow[i-1] && value[4*(i-1) +: 4] == 4'd0;
    end
    assign result[4*i +: 4] = !borrow[i] ? value[4*i +: 4] :
                              value[4*i +: 4] == 4'd0 ? 4'd9 : value[4*i +: 4] - 4'd1;
  end
endmodule

// File: rtl/keypad_countdown_ctrl.sv
// keypad_countdown_ctrl: keypad BCD entry, divided countdown and idle lockout
// Define KEYPAD_PAUSE_EN to let RUN toggle between RUN and PAUSE.
module keypad_countdown_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int TICK_DIV   = 50,
  parameter int IDLE_LIMIT = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          in,
  output logic [4*DIGITS-1:0] value,
  output logic                lock,
  output logic                running,
  output logic                err,
  output logic                done
);
  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};
  state_t state, nstate;
  logic [W-1:0] nvalue, dec;
  logic [4:0] prev;
  logic [TW-1:0] tick, ntick;
  logic [IW-1:0] idle, nidle;
  logic ndone, press, wrap, top_busy;
  bcd_decrement #(.DIGITS(DIGITS)) u_dec (.value(value), .result(dec));
  assign press    = in != KEY_NONE && prev == KEY_NONE;
  assign wrap     = tick == TW'(TICK_DIV - 1);
  assign top_busy = value[W-1 -: 4] != 4'd0;
  assign lock     = state == LOCK;
  assign err      = state == ERR;
  assign running  = state == RUN || state == PAUSE;
  always_comb begin
    nstate = state;
    nvalue = value;
    ntick  = tick;
    ndone  = 1'b0;
    nidle  = in == KEY_NONE && state inside {IDLE, ENTRY, DONE, ERR} ? idle + 1'b1 : '0;
    case (state)
      LOCK: if (press && in == KEY_ARM) begin
        nstate = IDLE;
        nvalue = '0;
      end
      IDLE, ENTRY, DONE: if (press && is_digit(in)) begin
        nstate = top_busy ? ERR : ENTRY;
        nvalue = top_busy ? NINES : W'({value, in[3:0]});
      end else if (press && in == KEY_CLEAR) begin
        nstate = IDLE;
        nvalue = '0;
      end else if (press && in == KEY_RUN) begin
        nstate = value == '0 ? DONE : RUN;
        ndone  = value == '0;
        ntick  = '0;
      end
      // CLEAR outranks a decrement landing on the same edge
      RUN: if (press && in == KEY_CLEAR) begin
        nstate = IDLE;
        nvalue = '0;
      end
`ifdef KEYPAD_PAUSE_EN
      else if (press && in == KEY_RUN) nstate = PAUSE;
`endif
      else begin
        ntick = wrap ? '0 : tick + 1'b1;
        if (wrap) begin
          nvalue = dec;
          nstate = dec == '0 ? DONE : RUN;
          ndone  = dec == '0;
        end
      end
`ifdef KEYPAD_PAUSE_EN
      PAUSE: if (press && in == KEY_CLEAR) begin
        nstate = IDLE;
        nvalue = '0;
      end else if (press && in == KEY_RUN) nstate = RUN;
`endif
      ERR: if (press && in == KEY_CLEAR) begin
        nstate = IDLE;
        nvalue = '0;
      end
      default: begin
        nstate = LOCK;
        nvalue = '0;
      end
    endcase
    if (nidle == IW'(IDLE_LIMIT)) begin
      nstate = LOCK;
      nvalue = '0;
      nidle  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOCK;
      value <= '0;
      prev  <= KEY_NONE;
      tick  <= '0;
      idle  <= '0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      value <= nvalue;
      prev  <= in;
      tick  <= ntick;
      idle  <= nidle;
      done  <= ndone;
    end
  end
endmodule
